// File: rtl/dsp_op_sequencer_pkg.sv
// rtl/dsp_op_sequencer_pkg.sv - shared mode/state encodings and phase-count helper
package dsp_op_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_Q   = 2'd0,
    MODE_H   = 2'd1,
    MODE_F   = 2'd2,
    MODE_MAC = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  function automatic logic [2:0] phase_count(input mode_e mode);
    case (mode)
      MODE_Q:  phase_count = 3'd1;
      MODE_H:  phase_count = 3'd2;
      default: phase_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dsp_op_sequencer_if.sv
// rtl/dsp_op_sequencer_if.sv - request, multiplier-control and result handshake bundle
interface dsp_op_sequencer_if #(
  parameter int N = 16,
  parameter int M = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_mode;
  logic         in_sgn;
  logic [N-1:0] in_a;
  logic [M-1:0] in_b;
  logic [N/2:0] mult_a;
  logic [M/2:0] mult_b;
  logic         phase_valid;
  logic         shift_a_hi;
  logic         shift_b_hi;
  logic         acc_clear;
  logic         last_phase;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_valid, in_mode, in_sgn, in_a, in_b, out_ready,
    input  in_ready, mult_a, mult_b, phase_valid, shift_a_hi, shift_b_hi,
           acc_clear, last_phase, out_valid
  );

  modport slave (
    input  in_valid, in_mode, in_sgn, in_a, in_b, out_ready,
    output in_ready, mult_a, mult_b, phase_valid, shift_a_hi, shift_b_hi,
           acc_clear, last_phase, out_valid
  );
endinterface

// File: rtl/dsp_half_select.sv
// rtl/dsp_half_select.sv - picks and extends the operand halves for one multiplier phase
module dsp_half_select
  import dsp_op_sequencer_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 16
) (
  input  logic [N-1:0] a,
  input  logic [M-1:0] b,
  input  mode_e        mode,
  input  logic         sgn,
  input  logic [1:0]   phase,
  output logic [N/2:0] mult_a,
  output logic [M/2:0] mult_b,
  output logic         shift_a_hi,
  output logic         shift_b_hi
);
  localparam int HN = N / 2;
  localparam int HM = M / 2;

  logic [HN-1:0] a_half;
  logic [HM-1:0] b_half;
  logic          a_top;
  logic          b_top;

  always_comb begin
    shift_a_hi = 1'b0;
    shift_b_hi = 1'b0;
    case (mode)
      MODE_Q: ;
      MODE_H: shift_b_hi = phase[0];
      default: begin
        shift_a_hi = phase[0];
        shift_b_hi = phase[1];
      end
    endcase
    // A half is the top of its operand when high is chosen, or when narrow modes use only A low
    a_top  = shift_a_hi | (mode == MODE_Q) | (mode == MODE_H);
    b_top  = shift_b_hi | (mode == MODE_Q);
    a_half = shift_a_hi ? a[N-1:HN] : a[HN-1:0];
    b_half = shift_b_hi ? b[M-1:HM] : b[HM-1:0];
    mult_a = {a_top & sgn & a_half[HN-1], a_half};
    mult_b = {b_top & sgn & b_half[HM-1], b_half};
  end
endmodule

// File: rtl/dsp_op_sequencer.sv
// rtl/dsp_op_sequencer.sv - phase sequencer and result tracker for the fracturable DSP datapath
module dsp_op_sequencer
  import dsp_op_sequencer_pkg::*;
#(
  parameter int N     = 16,
  parameter int M     = 16,
  parameter int PIPES = 2
) (
  input logic                clk,
  input logic                reset_n,
  dsp_op_sequencer_if.slave  bus
);
  localparam logic [1:0] PIPES_CNT = PIPES[1:0];

  state_e       state;
  mode_e        mode_q;
  logic         sgn_q;
  logic [N-1:0] a_q;
  logic [M-1:0] b_q;
  logic [1:0]   phase;
  logic [1:0]   drain;
  logic         in_ready_q;
  logic         phase_valid_q;
  logic         acc_clear_q;
  logic         last_phase_q;
  logic         out_valid_q;
  logic [N/2:0] sel_a;
  logic [M/2:0] sel_b;
  logic         sel_sa;
  logic         sel_sb;

  dsp_half_select #(.N(N), .M(M)) u_half_select (
    .a          (a_q),
    .b          (b_q),
    .mode       (mode_q),
    .sgn        (sgn_q),
    .phase      (phase),
    .mult_a     (sel_a),
    .mult_b     (sel_b),
    .shift_a_hi (sel_sa),
    .shift_b_hi (sel_sb)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      mode_q        <= MODE_Q;
      sgn_q         <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      phase         <= '0;
      drain         <= '0;
      in_ready_q    <= 1'b1;
      phase_valid_q <= 1'b0;
      acc_clear_q   <= 1'b0;
      last_phase_q  <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          mode_q        <= mode_e'(bus.in_mode);
          sgn_q         <= bus.in_sgn;
          a_q           <= bus.in_a;
          b_q           <= bus.in_b;
          phase         <= '0;
          in_ready_q    <= 1'b0;
          phase_valid_q <= 1'b1;
          acc_clear_q   <= (mode_e'(bus.in_mode) != MODE_MAC);
          last_phase_q  <= (phase_count(mode_e'(bus.in_mode)) == 3'd1);
          state         <= RUN;
        end
        RUN: begin
          acc_clear_q <= 1'b0;
          if (last_phase_q) begin
            phase         <= '0;
            phase_valid_q <= 1'b0;
            last_phase_q  <= 1'b0;
            if (PIPES == 0) begin
              out_valid_q <= 1'b1;
              state       <= HOLD;
            end else begin
              drain <= PIPES_CNT;
              state <= DRAIN;
            end
          end else begin
            phase        <= phase + 2'd1;
            last_phase_q <= (({1'b0, phase} + 3'd2) == phase_count(mode_q));
          end
        end
        DRAIN: begin
          drain <= drain - 2'd1;
          if (drain == 2'd1) begin
            out_valid_q <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand/shift outputs only carry meaning while a phase is being issued
  assign bus.mult_a      = phase_valid_q ? sel_a : '0;
  assign bus.mult_b      = phase_valid_q ? sel_b : '0;
  assign bus.shift_a_hi  = phase_valid_q & sel_sa;
  assign bus.shift_b_hi  = phase_valid_q & sel_sb;
  assign bus.in_ready    = in_ready_q;
  assign bus.phase_valid = phase_valid_q;
  assign bus.acc_clear   = acc_clear_q;
  assign bus.last_phase  = last_phase_q;
  assign bus.out_valid   = out_valid_q;
endmodule

// File: tb/tb_dsp_op_sequencer.sv
// tb/tb_dsp_op_sequencer.sv - randomized self-checking bench for dsp_op_sequencer
module tb_dsp_op_sequencer;
  localparam int PIPES = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dsp_op_sequencer_if #(.N(8), .M(8)) ifc ();
  dsp_op_sequencer_if #(.N(8), .M(8)) if0 ();

  dsp_op_sequencer #(.N(8), .M(8), .PIPES(PIPES)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(ifc)
  );
  dsp_op_sequencer #(.N(8), .M(8), .PIPES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic       q_valid = 1'b0;
  logic [1:0] q_mode;
  logic       q_sgn;
  logic [7:0] q_a;
  logic [7:0] q_b;

  // Reference: phase list and half extension straight from the operation definition
  function automatic int phase_total(input int mode);
    return (mode == 0) ? 1 : (mode == 1) ? 2 : 4;
  endfunction

  function automatic int a_hi_of(input int mode, input int i);
    return (mode >= 2) ? i % 2 : 0;
  endfunction

  function automatic int b_hi_of(input int mode, input int i);
    return (mode >= 2) ? i / 2 : (mode == 1) ? i : 0;
  endfunction

  function automatic logic [4:0] exp_half(input logic [7:0] v, input int hi, input int top,
                                          input logic sgn);
    int h;
    h = (hi != 0) ? int'(v) / 16 : int'(v) % 16;
    if (top != 0 && sgn && h >= 8) h = h + 16;
    return 5'(h);
  endfunction

  function automatic logic [6:0] flags_main();
    return {ifc.phase_valid, ifc.shift_b_hi, ifc.shift_a_hi, ifc.acc_clear,
            ifc.last_phase, ifc.in_ready, ifc.out_valid};
  endfunction

  function automatic logic [6:0] flags_p0();
    return {if0.phase_valid, if0.shift_b_hi, if0.shift_a_hi, if0.acc_clear,
            if0.last_phase, if0.in_ready, if0.out_valid};
  endfunction

  task automatic scramble();
    ifc.in_a    = 8'($urandom);
    ifc.in_b    = 8'($urandom);
    ifc.in_mode = 2'($urandom);
    ifc.in_sgn  = 1'($urandom);
  endtask

  // Starts and ends just after a falling edge
  task automatic run_op(input logic [1:0] mode, input logic sgn, input logic [7:0] a,
                        input logic [7:0] b, input int hold, input string tag);
    int cnt, w, lat, ah, bh;
    logic [4:0] ea, eb;
    logic [6:0] ef;
    cnt = phase_total(int'(mode));
    ifc.in_valid = 1'b1;
    ifc.in_mode  = mode;
    ifc.in_sgn   = sgn;
    ifc.in_a     = a;
    ifc.in_b     = b;
    w = 0;
    while (ifc.in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (w >= 50) begin
      n_fail++;
      $display("FAIL %s accept_timeout in_ready=%b required=1", tag, ifc.in_ready);
      ifc.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    scramble();
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      ah = a_hi_of(int'(mode), i);
      bh = b_hi_of(int'(mode), i);
      ea = exp_half(a, ah, (ah != 0 || mode < 2) ? 1 : 0, sgn);
      eb = exp_half(b, bh, (bh != 0 || mode == 0) ? 1 : 0, sgn);
      ef = {1'b1, 1'(bh), 1'(ah), (i == 0 && mode != 2'd3), (i == cnt - 1), 1'b0, 1'b0};
      n_cmp++;
      if (ifc.mult_a !== ea) begin
        n_fail++;
        $display("FAIL %s ph%0d mult_a got=%h required=%h", tag, i, ifc.mult_a, ea);
      end
      n_cmp++;
      if (ifc.mult_b !== eb) begin
        n_fail++;
        $display("FAIL %s ph%0d mult_b got=%h required=%h", tag, i, ifc.mult_b, eb);
      end
      n_cmp++;
      if (flags_main() !== ef) begin
        n_fail++;
        $display("FAIL %s ph%0d flags got=%b required=%b", tag, i, flags_main(), ef);
      end
      if (i < cnt - 1) begin
        @(posedge clk);
        #1;
        scramble();
      end
    end
    lat = cnt - 1;
    do begin
      @(posedge clk);
      #1;
      scramble();
      lat++;
      @(negedge clk);
    end while (ifc.out_valid !== 1'b1 && lat < cnt + PIPES + 10);
    n_cmp++;
    if (lat != cnt + PIPES) begin
      n_fail++;
      $display("FAIL %s latency got=%0d required=%0d", tag, lat, cnt + PIPES);
    end
    n_cmp++;
    if ({ifc.mult_a, ifc.mult_b, flags_main()} !== {5'd0, 5'd0, 7'b0000001}) begin
      n_fail++;
      $display("FAIL %s result_idle got=%h/%h/%b required=0/0/0000001", tag,
               ifc.mult_a, ifc.mult_b, flags_main());
    end
    if (q_valid) begin
      ifc.in_valid = 1'b1;
      ifc.in_mode  = q_mode;
      ifc.in_sgn   = q_sgn;
      ifc.in_a     = q_a;
      ifc.in_b     = q_b;
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      n_cmp++;
      if (flags_main() !== 7'b0000001) begin
        n_fail++;
        $display("FAIL %s hold%0d flags got=%b required=0000001", tag, k, flags_main());
      end
    end
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (flags_main() !== 7'b0000010) begin
      n_fail++;
      $display("FAIL %s release flags got=%b required=0000010", tag, flags_main());
    end
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    if0.in_valid  = 1'b0;
    if0.out_ready = 1'b0;
    if0.in_mode   = 2'd0;
    if0.in_sgn    = 1'b0;
    if0.in_a      = 8'd0;
    if0.in_b      = 8'd0;
    scramble();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ifc.mult_a, ifc.mult_b, flags_main()} !== {5'd0, 5'd0, 7'b0000010}) begin
      n_fail++;
      $display("FAIL reset_main got=%h/%h/%b required=0/0/0000010",
               ifc.mult_a, ifc.mult_b, flags_main());
    end
    n_cmp++;
    if ({if0.mult_a, if0.mult_b, flags_p0()} !== {5'd0, 5'd0, 7'b0000010}) begin
      n_fail++;
      $display("FAIL reset_p0 got=%h/%h/%b required=0/0/0000010",
               if0.mult_a, if0.mult_b, flags_p0());
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (flags_main() !== 7'b0000010) begin
      n_fail++;
      $display("FAIL reset_release flags got=%b required=0000010", flags_main());
    end
  endtask

  task automatic test_plan_vector();
    run_op(2'd2, 1'b1, 8'hFD, 8'h05, 0, "plan_mode2");
  endtask

  task automatic test_pipes0();
    if0.in_valid = 1'b1;
    if0.in_mode  = 2'd0;
    if0.in_sgn   = 1'b0;
    if0.in_a     = 8'h0F;
    if0.in_b     = 8'h0E;
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0;
    if0.in_a     = 8'hA5;
    if0.in_b     = 8'h5A;
    @(negedge clk);
    n_cmp++;
    if ({if0.mult_a, if0.mult_b, flags_p0()} !== {5'h0F, 5'h0E, 7'b1001100}) begin
      n_fail++;
      $display("FAIL pipes0_phase got=%h/%h/%b required=0f/0e/1001100",
               if0.mult_a, if0.mult_b, flags_p0());
    end
    @(negedge clk);
    n_cmp++;
    if (flags_p0() !== 7'b0000001) begin
      n_fail++;
      $display("FAIL pipes0_result flags got=%b required=0000001", flags_p0());
    end
    if0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if0.out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (flags_p0() !== 7'b0000010) begin
      n_fail++;
      $display("FAIL pipes0_release flags got=%b required=0000010", flags_p0());
    end
  endtask

  task automatic test_mac();
    run_op(2'd2, 1'($urandom), 8'($urandom), 8'($urandom), 0, "mac_first");
    run_op(2'd3, 1'($urandom), 8'($urandom), 8'($urandom), 1, "mac_accum");
  endtask

  task automatic test_back_to_back();
    q_valid = 1'b1;
    q_mode  = 2'd1;
    q_sgn   = 1'b1;
    q_a     = 8'($urandom);
    q_b     = 8'($urandom);
    run_op(2'd2, 1'b0, 8'($urandom), 8'($urandom), 5, "b2b_first");
    q_valid = 1'b0;
    run_op(q_mode, q_sgn, q_a, q_b, 0, "b2b_queued");
  endtask

  task automatic test_reset_mid_op();
    ifc.in_valid = 1'b1;
    ifc.in_mode  = 2'd2;
    ifc.in_sgn   = 1'b1;
    ifc.in_a     = 8'($urandom);
    ifc.in_b     = 8'($urandom);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ifc.phase_valid, ifc.shift_b_hi, ifc.shift_a_hi} !== 3'b110) begin
      n_fail++;
      $display("FAIL midreset_phase2 got=%b required=110",
               {ifc.phase_valid, ifc.shift_b_hi, ifc.shift_a_hi});
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({ifc.mult_a, ifc.mult_b, flags_main()} !== {5'd0, 5'd0, 7'b0000010}) begin
      n_fail++;
      $display("FAIL midreset_async got=%h/%h/%b required=0/0/0000010",
               ifc.mult_a, ifc.mult_b, flags_main());
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_op(2'd1, 1'($urandom), 8'($urandom), 8'($urandom), 0, "after_reset_mode1");
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++)
      run_op(2'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
             int'($urandom_range(0, 3)), "random");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_plan_vector();
    test_pipes0();
    test_mac();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
